uart_bus_slave: RTL and testbench

Memory-mapped 8N1 UART that answers the pipelined CPU's data-memory bus in the MEM stage, alongside data memory and the LED/switch/digit peripheral. The CPU is the bus initiator: it writes a byte to transmit, reads received bytes and status, and takes an interrupt on `irq`. Reads are combinational so the CPU sees read data in the same cycle. Register side effects take place on the clock edge.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_rx_fsm.sv | 100 ++++++++++
 rtl/uart_bus_slave.sv | 214 +++++++++++++++++++++
 tb/tb_uart_bus_slave.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: bus addresses, CON register
// bit positions, TX/RX state encodings and a counter-width helper.
package uart_pkg;

    localparam logic [31:0] ADDR_TXD = 32'h4000_0018;
    localparam logic [31:0] ADDR_RXD = 32'h4000_001C;
    localparam logic [31:0] ADDR_CON = 32'h4000_0020;

    localparam int CON_TX_IE    = 0;
    localparam int CON_RX_IE    = 1;
    localparam int CON_TX_DONE  = 2;
    localparam int CON_RX_VALID = 3;
    localparam int CON_TX_BUSY  = 4;
    localparam int CON_OVERRUN  = 5;
    localparam int CON_LOOPBACK = 6;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // Width of a counter that must reach clks-1 (never narrower than 1 bit).
    function automatic int cnt_width(input int clks);
        return (clks <= 2) ? 1 : $clog2(clks);
    endfunction

endpackage

// File: rtl/uart_rx_fsm.sv
// 8N1 receiver: two-flop synchronizer, falling-edge start detection,
// mid-bit sampling and LSB-first shifting. Emits the received byte together
// with a one-cycle frame_ok pulse for every frame whose stop bit is high.
// CLKS_PER_BIT must be at least 4 so the half-bit point is well defined.
module uart_rx_fsm
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    output logic [7:0] rx_byte,
    output logic       frame_ok
);

    localparam int              CW        = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0]   FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic          sync_meta;
    logic          sync_line;
    logic          line_prev;
    rx_state_t     state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    // Resynchronise the asynchronous line and keep one older copy for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_meta <= 1'b1;
            sync_line <= 1'b1;
            line_prev <= 1'b1;
        end else begin
            sync_meta <= rx_in;
            sync_line <= sync_meta;
            line_prev <= sync_line;
        end
    end

    // Frame receiver: start-bit qualification at half a bit, then one sample per bit centre.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= RX_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            frame_ok <= 1'b0;
        end else begin
            frame_ok <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (line_prev && !sync_line) begin
                        state <= RX_START;
                        cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= sync_line ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt == FULL_LAST) begin
                        cnt   <= '0;
                        shift <= {sync_line, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt == FULL_LAST) begin
                        cnt      <= '0;
                        state    <= RX_IDLE;
                        frame_ok <= sync_line;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= RX_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign rx_byte = shift;

endmodule

// File: rtl/uart_bus_slave.sv
// Memory-mapped 8N1 UART on the CPU data bus: TXD/RXD/CON registers,
// transmitter FSM, status flags and a level interrupt. Reads are
// combinational; every register side effect happens on the clock edge.
// Optional feature: define UART_LOOPBACK_EN to make CON[6] a loopback
// control that feeds the internal TX line into the receiver.
module uart_bus_slave
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 9600
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);

    localparam int            CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int            CW           = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_LAST    = CW'(CLKS_PER_BIT - 1);

    logic          hit_txd;
    logic          hit_rxd;
    logic          hit_con;
    logic          wr_txd;
    logic          wr_con;
    logic          rd_con;
    logic          rd_rxd;

    tx_state_t     tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_byte;
    logic          tx_line;
    logic          tx_done;
    logic          tx_busy;

    logic          tx_ie;
    logic          rx_ie;
    logic          rx_valid;
    logic          overrun;
    logic [7:0]    rx_data;
    logic          loopback;

    logic          rx_in;
    logic [7:0]    rx_byte;
    logic          frame_ok;
    logic [31:0]   con_value;
    logic          unused_wdata;

    assign hit_txd = (addr == ADDR_TXD);
    assign hit_rxd = (addr == ADDR_RXD);
    assign hit_con = (addr == ADDR_CON);
    assign wr_txd  = wr & hit_txd;
    assign wr_con  = wr & hit_con;
    assign rd_con  = rd & hit_con;
    assign rd_rxd  = rd & hit_rxd;

    assign tx_busy = (tx_state != TX_IDLE);

    // Transmitter: start, eight data bits LSB first, stop; the line register changes with the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_byte  <= '0;
            tx_line  <= 1'b1;
            tx_done  <= 1'b0;
        end else begin
            if (rd_con) begin
                tx_done <= 1'b0;
            end
            case (tx_state)
                TX_IDLE: begin
                    if (wr_txd) begin
                        tx_byte  <= wdata[7:0];
                        tx_line  <= 1'b0;
                        tx_cnt   <= '0;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt == FULL_LAST) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        tx_line  <= tx_byte[0];
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == FULL_LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            tx_line  <= 1'b1;
                            tx_state <= TX_STOP;
                        end else begin
                            tx_bit  <= tx_bit + 3'd1;
                            tx_line <= tx_byte[tx_bit + 3'd1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == FULL_LAST) begin
                        tx_cnt   <= '0;
                        tx_state <= TX_IDLE;
                        tx_done  <= 1'b1;
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                default: begin
                    tx_state <= TX_IDLE;
                    tx_cnt   <= '0;
                    tx_line  <= 1'b1;
                end
            endcase
        end
    end

    // Control and receive status; a flag being set in the same cycle as its clearing read wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_ie    <= 1'b0;
            rx_ie    <= 1'b0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
            rx_data  <= '0;
        end else begin
            if (wr_con) begin
                tx_ie <= wdata[CON_TX_IE];
                rx_ie <= wdata[CON_RX_IE];
            end
            if (rd_con) begin
                overrun <= 1'b0;
            end
            if (rd_rxd) begin
                rx_valid <= 1'b0;
            end
            if (frame_ok) begin
                rx_data  <= rx_byte;
                rx_valid <= 1'b1;
                if (rx_valid) begin
                    overrun <= 1'b1;
                end
            end
        end
    end

`ifdef UART_LOOPBACK_EN
    // Loopback control bit; when set the receiver listens to our own TX line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            loopback <= 1'b0;
        end else if (wr_con) begin
            loopback <= wdata[CON_LOOPBACK];
        end
    end

    assign rx_in = loopback ? tx_line : uart_rx;
`else
    assign loopback = 1'b0;
    assign rx_in    = uart_rx;
`endif

    uart_rx_fsm #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk      (clk),
        .reset    (reset),
        .rx_in    (rx_in),
        .rx_byte  (rx_byte),
        .frame_ok (frame_ok)
    );

    // Assemble the CON read view from the individual flags.
    always_comb begin
        con_value               = '0;
        con_value[CON_TX_IE]    = tx_ie;
        con_value[CON_RX_IE]    = rx_ie;
        con_value[CON_TX_DONE]  = tx_done;
        con_value[CON_RX_VALID] = rx_valid;
        con_value[CON_TX_BUSY]  = tx_busy;
        con_value[CON_OVERRUN]  = overrun;
        con_value[CON_LOOPBACK] = loopback;
    end

    // Combinational read mux so the CPU sees data in the same MEM-stage cycle.
    always_comb begin
        rdata = '0;
        if (rd) begin
            if (hit_rxd) begin
                rdata = {24'h0, rx_data};
            end else if (hit_con) begin
                rdata = con_value;
            end
        end
    end

    assign uart_tx      = tx_line;
    assign irq          = (tx_ie & tx_done) | (rx_ie & rx_valid);
    assign unused_wdata = ^wdata[31:8];

endmodule

// File: tb/tb_uart_bus_slave.sv
// Self-checking bench for uart_bus_slave at 16 clocks per bit. Expected
// values come from a small register model and from frame shapes computed
// arithmetically; RX cases are driven from a vector table.
module tb_uart_bus_slave;

    localparam int          CPB   = 16;
    localparam int          FRAME = 10 * CPB;
    localparam logic [31:0] A_TXD = 32'h4000_0018;
    localparam logic [31:0] A_RXD = 32'h4000_001C;
    localparam logic [31:0] A_CON = 32'h4000_0020;
    localparam logic [31:0] A_BAD = 32'h4000_0024;
    localparam int          K_GOOD    = 0;
    localparam int          K_GLITCH  = 1;
    localparam int          K_BADSTOP = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
        bit         exp_valid;
        logic [7:0] exp_rxd;
    } rx_vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd, wr, uart_rx, uart_tx, irq;
    logic [31:0] addr, wdata, rdata;

    int checks = 0;
    int errors = 0;

    bit         m_tx_ie, m_rx_ie, m_tx_done, m_rx_valid, m_overrun, m_loop;
    logic [7:0] m_rx_data;

    rx_vec_t     vecs[$];
    logic [159:0] line_bits, busy_bits;
    logic [31:0]  got, idle_bits;

    always #5 clk = ~clk;

    uart_bus_slave #(
        .CLK_HZ (16),
        .BAUD   (1)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .rd      (rd),
        .wr      (wr),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .uart_rx (uart_rx),
        .uart_tx (uart_tx),
        .irq     (irq)
    );

    function automatic logic [31:0] model_con();
        return {25'd0, m_loop, m_overrun, 1'b0, m_rx_valid, m_tx_done, m_rx_ie, m_tx_ie};
    endfunction

    function automatic logic [31:0] model_irq();
        return 32'((m_tx_ie & m_tx_done) | (m_rx_ie & m_rx_valid));
    endfunction

    function automatic logic [31:0] expected_read(input logic [31:0] a);
        if (a == A_CON) return model_con();
        if (a == A_RXD) return {24'd0, m_rx_data};
        return 32'd0;
    endfunction

    // Line level k cycles into a frame: start bit, data LSB first, stop bit.
    function automatic logic [159:0] expected_frame(input logic [7:0] b);
        logic [159:0] v;
        int slot;
        for (int k = 0; k < FRAME; k++) begin
            slot = k / CPB;
            if (slot == 0)      v[k] = 1'b0;
            else if (slot == 9) v[k] = 1'b1;
            else                v[k] = b[slot-1];
        end
        return v;
    endfunction

    function automatic void model_good_frame(input logic [7:0] b);
        if (m_rx_valid) m_overrun = 1'b1;
        m_rx_valid = 1'b1;
        m_rx_data  = b;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic check_frame(input string name, input logic [159:0] actual, input logic [159:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        wr = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        wr = 1'b0; addr = '0; wdata = '0;
        if (a == A_CON) begin
            m_tx_ie = d[0];
            m_rx_ie = d[1];
`ifdef UART_LOOPBACK_EN
            m_loop  = d[6];
`endif
        end
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        rd = 1'b1; addr = a;
        #1 d = rdata;
        @(negedge clk);
        rd = 1'b0; addr = '0;
        if (a == A_CON) begin
            m_tx_done = 1'b0;
            m_overrun = 1'b0;
        end
        if (a == A_RXD) m_rx_valid = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [31:0] a);
        logic [31:0] exp_v, d;
        exp_v = expected_read(a);
        bus_read(a, d);
        check_output(name, d, exp_v);
    endtask

    task automatic drive_rx_frame(input logic [7:0] b, input logic stop);
        for (int k = 0; k < 10; k++) begin
            if (k == 0)      uart_rx = 1'b0;
            else if (k == 9) uart_rx = stop;
            else             uart_rx = b[k-1];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = 1'b1;
    endtask

    // Write TXD, then record the line and tx_busy every cycle of the frame.
    // At inject_at a second TXD write of 0xFF is issued instead of the CON read.
    task automatic send_and_capture(input logic [7:0] b, input int inject_at,
                                    output logic [159:0] lines, output logic [159:0] busy);
        wr = 1'b1; addr = A_TXD; wdata = {24'd0, b};
        #1 check_output("tx idle in write cycle", 32'(uart_tx), 32'd1);
        @(negedge clk);
        for (int k = 0; k < FRAME; k++) begin
            if (k == inject_at) begin
                rd = 1'b0; wr = 1'b1; addr = A_TXD; wdata = 32'hFF;
            end else begin
                wr = 1'b0; rd = 1'b1; addr = A_CON; wdata = '0;
            end
            #1;
            lines[k] = uart_tx;
            busy[k]  = (k == inject_at) ? 1'b1 : rdata[4];
            @(negedge clk);
        end
        rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        m_overrun = 1'b0;
        m_tx_done = 1'b1;
    endtask

    task automatic capture_idle(output logic [31:0] v);
        for (int k = 0; k < 32; k++) begin
            #1 v[k] = uart_tx;
            @(negedge clk);
        end
    endtask

    task automatic apply_stimulus(input int idx, input rx_vec_t v);
        logic [31:0] d;
        case (v.kind)
            K_GOOD:    drive_rx_frame(v.data, 1'b1);
            K_BADSTOP: drive_rx_frame(v.data, 1'b0);
            default: begin
                uart_rx = 1'b0;
                repeat (4) @(negedge clk);
                uart_rx = 1'b1;
            end
        endcase
        repeat (24) @(negedge clk);
        if (v.kind == K_GOOD) model_good_frame(v.data);
        check_output($sformatf("rx%0d irq", idx), 32'(irq), 32'(v.exp_valid));
        bus_read(A_RXD, d);
        check_output($sformatf("rx%0d rxd", idx), d, {24'd0, v.exp_rxd});
        read_check($sformatf("rx%0d con after rxd read", idx), A_CON);
    endtask

    function automatic rx_vec_t mk(input int kind, input logic [7:0] data, input logic [7:0] last);
        rx_vec_t v;
        v.kind      = kind;
        v.data      = data;
        v.exp_valid = (kind == K_GOOD);
        v.exp_rxd   = (kind == K_GOOD) ? data : last;
        return v;
    endfunction

    initial begin
        #1_000_000;
        errors++;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        logic [7:0] b, last;
        int         kind;
        rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; uart_rx = 1'b1;
        {m_tx_ie, m_rx_ie, m_tx_done, m_rx_valid, m_overrun, m_loop} = '0;
        m_rx_data = '0;

        // Reset and idle state
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        #1 check_output("tx high in reset", 32'(uart_tx), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_output("tx idle after reset", 32'(uart_tx), 32'd1);
        check_output("irq after reset", 32'(irq), 32'd0);
        read_check("con after reset", A_CON);
        read_check("rxd after reset", A_RXD);

        // Transmit 0x55 with tx_ie set
        bus_write(A_CON, 32'h1);
        send_and_capture(8'h55, -1, line_bits, busy_bits);
        check_frame("tx frame 55", line_bits, expected_frame(8'h55));
        check_frame("tx busy 55", busy_bits, {160{1'b1}});
        check_output("irq after tx 55", 32'(irq), model_irq());
        read_check("con after tx 55", A_CON);
        read_check("con tx_done cleared", A_CON);
        check_output("irq after con read", 32'(irq), model_irq());

        // Read and write of CON in the same cycle: read sees the old value
        rd = 1'b1; wr = 1'b1; addr = A_CON; wdata = 32'h2;
        #1 got = rdata;
        @(negedge clk);
        rd = 1'b0; wr = 1'b0;
        check_output("con rd+wr old value", got, model_con());
        m_tx_ie = 1'b0; m_rx_ie = 1'b1; m_tx_done = 1'b0; m_overrun = 1'b0;
        read_check("con after rd+wr", A_CON);
        addr = A_CON; rd = 1'b0;
        #1 check_output("rdata with rd low", rdata, 32'd0);
        @(negedge clk);
        read_check("unmapped read", A_BAD);
        read_check("txd read", A_TXD);

        // Table of receive cases, fixed ones first then randomized frames
        vecs.push_back(mk(K_GOOD,    8'hA3, 8'h00));
        vecs.push_back(mk(K_GLITCH,  8'h00, 8'hA3));
        vecs.push_back(mk(K_BADSTOP, 8'h5A, 8'hA3));
        vecs.push_back(mk(K_GOOD,    8'h00, 8'hA3));
        vecs.push_back(mk(K_GOOD,    8'hFF, 8'h00));
        last = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            b    = 8'($urandom);
            kind = ($urandom_range(0, 3) == 0) ? K_BADSTOP : K_GOOD;
            vecs.push_back(mk(kind, b, last));
            if (kind == K_GOOD) last = b;
        end
        foreach (vecs[i]) apply_stimulus(i, vecs[i]);

        // Two frames without reading: overrun, newest byte kept
        drive_rx_frame(8'h11, 1'b1);
        drive_rx_frame(8'h22, 1'b1);
        repeat (24) @(negedge clk);
        model_good_frame(8'h11);
        model_good_frame(8'h22);
        check_output("irq on overrun", 32'(irq), model_irq());
        read_check("con overrun", A_CON);
        read_check("rxd after overrun", A_RXD);
        read_check("con overrun cleared", A_CON);

        // Randomized transmits with an ignored TXD write during the frame
        for (int t = 0; t < 3; t++) begin
            b = 8'($urandom);
            bus_write(A_CON, {31'd0, 1'($urandom)});
            send_and_capture(b, (t == 0) ? 50 : $urandom_range(20, 140), line_bits, busy_bits);
            check_frame($sformatf("tx%0d frame", t), line_bits, expected_frame(b));
            check_frame($sformatf("tx%0d busy", t), busy_bits, {160{1'b1}});
            check_output($sformatf("tx%0d irq", t), 32'(irq), model_irq());
            capture_idle(idle_bits);
            check_output($sformatf("tx%0d no second frame", t), idle_bits, 32'hFFFF_FFFF);
            read_check($sformatf("tx%0d con", t), A_CON);
        end

`ifdef UART_LOOPBACK_EN
        // Loopback: our own transmission is received
        bus_write(A_CON, 32'h40);
        read_check("con loopback set", A_CON);
        send_and_capture(8'h3C, -1, line_bits, busy_bits);
        check_frame("loopback tx frame", line_bits, expected_frame(8'h3C));
        repeat (24) @(negedge clk);
        model_good_frame(8'h3C);
        read_check("con after loopback", A_CON);
        read_check("rxd loopback", A_RXD);
        bus_write(A_CON, 32'h0);
`else
        // Loopback not built: CON[6] ignored and the transmission is not received
        bus_write(A_CON, 32'h42);
        read_check("con bit6 ignored", A_CON);
        send_and_capture(8'h3C, -1, line_bits, busy_bits);
        check_frame("tx frame 3c", line_bits, expected_frame(8'h3C));
        repeat (24) @(negedge clk);
        check_output("no loopback irq", 32'(irq), model_irq());
        read_check("con no loopback rx", A_CON);
`endif

        // Reset asserted in the middle of a transmission
        bus_write(A_TXD, 32'h0);
        repeat (40) @(negedge clk);
        #1 check_output("tx low mid-frame", 32'(uart_tx), 32'd0);
        reset = 1'b0;
        #1 check_output("tx high on async reset", 32'(uart_tx), 32'd1);
        check_output("irq in reset", 32'(irq), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        {m_tx_ie, m_rx_ie, m_tx_done, m_rx_valid, m_overrun, m_loop} = '0;
        m_rx_data = '0;
        capture_idle(idle_bits);
        check_output("tx frame abandoned", idle_bits, 32'hFFFF_FFFF);
        read_check("con after mid-frame reset", A_CON);
        read_check("rxd after mid-frame reset", A_RXD);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
